// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two valid/ready requesters feeding one registered mux output.
// Each grant lasts up to MAX_BURST beats; the block also counts accepted beats per requester.
//
// state  | meaning
// IDLE   | no grant; arbitration cycle, no beat accepted
// GRANT0 | requester 0 owns the output, selector = 0
// GRANT1 | requester 1 owns the output, selector = 1
module mux_rr_arbiter #(
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 6
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in0,
  output logic              ready_in0,
  input  logic              valid_in1,
  input  logic [DATA_W-1:0] data_in1,
  output logic              ready_in1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              selector,
  output logic [CNT_W-1:0]  beat_cnt0,
  output logic [CNT_W-1:0]  beat_cnt1
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state;
  logic               prio;
  logic [BURST_W-1:0] burst;
  logic               load_en;
  logic               xfer0;
  logic               xfer1;
  logic               rel0;
  logic               rel1;

  assign load_en   = !valid_out || ready_out;
  assign ready_in0 = load_en && (state == GRANT0);
  assign ready_in1 = load_en && (state == GRANT1);
  assign xfer0     = valid_in0 && ready_in0;
  assign xfer1     = valid_in1 && ready_in1;
  // A grant ends when its owner goes quiet or has just delivered its last burst beat.
  assign rel0      = !valid_in0 || (xfer0 && (burst == BURST_LAST));
  assign rel1      = !valid_in1 || (xfer1 && (burst == BURST_LAST));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      selector  <= 1'b0;
      prio      <= 1'b0;
      burst     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      beat_cnt0 <= '0;
      beat_cnt1 <= '0;
    end else begin
      if (xfer0) begin
        data_out  <= data_in0;
        valid_out <= 1'b1;
        beat_cnt0 <= beat_cnt0 + 1'b1;
        burst     <= burst + 1'b1;
      end else if (xfer1) begin
        data_out  <= data_in1;
        valid_out <= 1'b1;
        beat_cnt1 <= beat_cnt1 + 1'b1;
        burst     <= burst + 1'b1;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end

      // Grant entry below overrides the burst increment above.
      case (state)
        IDLE: begin
          if (valid_in0 && (!valid_in1 || !prio)) begin
            state    <= GRANT0;
            selector <= 1'b0;
            burst    <= '0;
            prio     <= 1'b1;
          end else if (valid_in1) begin
            state    <= GRANT1;
            selector <= 1'b1;
            burst    <= '0;
            prio     <= 1'b0;
          end
        end
        GRANT0: begin
          if (rel0) begin
            if (valid_in1) begin
              state    <= GRANT1;
              selector <= 1'b1;
              burst    <= '0;
              prio     <= 1'b0;
            end else if (valid_in0) begin
              state    <= GRANT0;
              selector <= 1'b0;
              burst    <= '0;
              prio     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GRANT1: begin
          if (rel1) begin
            if (valid_in0) begin
              state    <= GRANT0;
              selector <= 1'b0;
              burst    <= '0;
              prio     <= 1'b1;
            end else if (valid_in1) begin
              state    <= GRANT1;
              selector <= 1'b1;
              burst    <= '0;
              prio     <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter, checked cycle by cycle
// against an owner/beats-taken reference model.
module tb_mux_rr_arbiter;

  localparam int DATA_W    = 2;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 6;
  localparam int CNT_MOD   = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              valid_in0 = 1'b0;
  logic [DATA_W-1:0] data_in0 = '0;
  logic              ready_in0;
  logic              valid_in1 = 1'b0;
  logic [DATA_W-1:0] data_in1 = '0;
  logic              ready_in1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_out = 1'b0;
  logic              selector;
  logic [CNT_W-1:0]  beat_cnt0;
  logic [CNT_W-1:0]  beat_cnt1;

  mux_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid_in0 (valid_in0),
    .data_in0  (data_in0),
    .ready_in0 (ready_in0),
    .valid_in1 (valid_in1),
    .data_in1  (data_in1),
    .ready_in1 (ready_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .selector  (selector),
    .beat_cnt0 (beat_cnt0),
    .beat_cnt1 (beat_cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the output (-1 = nobody), beats taken in this grant,
  // who wins the next tie, and the visible output registers.
  int owner;
  int taken;
  int pref;
  int m_sel;
  int m_dout;
  int m_vout;
  int m_cnt [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    taken  = 0;
    pref   = 0;
    m_sel  = 0;
    m_dout = 0;
    m_vout = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic grant(input int k);
    owner = k;
    taken = 0;
    pref  = 1 - k;
    m_sel = k;
  endtask

  task automatic compare_all();
    int go;
    go = (m_vout == 0 || ready_out) ? 1 : 0;
    check_val("ready_in0", 32'(ready_in0), 32'((owner == 0 && go == 1) ? 1 : 0));
    check_val("ready_in1", 32'(ready_in1), 32'((owner == 1 && go == 1) ? 1 : 0));
    check_val("data_out",  32'(data_out),  32'(m_dout));
    check_val("valid_out", 32'(valid_out), 32'(m_vout));
    check_val("selector",  32'(selector),  32'(m_sel));
    check_val("beat_cnt0", 32'(beat_cnt0), 32'(m_cnt[0]));
    check_val("beat_cnt1", 32'(beat_cnt1), 32'(m_cnt[1]));
  endtask

  task automatic model_step();
    int v [2];
    int d [2];
    int go, xf, n, o;
    v[0] = int'(valid_in0);
    v[1] = int'(valid_in1);
    d[0] = int'(data_in0);
    d[1] = int'(data_in1);
    go = (m_vout == 0 || ready_out) ? 1 : 0;
    xf = -1;
    if (owner >= 0 && go == 1 && v[owner] == 1) xf = owner;
    if (xf >= 0) begin
      m_dout = d[xf];
      m_vout = 1;
      m_cnt[xf] = (m_cnt[xf] + 1) % CNT_MOD;
      taken++;
    end else if (ready_out) begin
      m_vout = 0;
    end
    if (owner < 0) begin
      if (v[0] == 1 && v[1] == 1) grant(pref);
      else if (v[0] == 1) grant(0);
      else if (v[1] == 1) grant(1);
    end else begin
      n = owner;
      o = 1 - n;
      if (v[n] == 0 || (xf == n && taken == MAX_BURST)) begin
        if (v[o] == 1) grant(o);
        else if (v[n] == 1) grant(n);
        else owner = -1;
      end
    end
  endtask

  // Called at a falling edge: drive inputs, check, advance model, wait for next falling edge.
  task automatic cycle(input logic v0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [DATA_W-1:0] d1, input logic ro);
    valid_in0 = v0;
    data_in0  = d0;
    valid_in1 = v1;
    data_in1  = d1;
    ready_out = ro;
    #1;
    compare_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;

    repeat (2) cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    repeat (4) cycle(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    repeat (20) cycle(1'b1, 2'b01, 1'b1, 2'b11, 1'b1);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    repeat (11) cycle(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    repeat (3) cycle(1'b1, 2'b01, 1'b0, 2'b00, 1'b1);
    repeat (3) cycle(1'b1, 2'b10, 1'b0, 2'b00, 1'b0);
    repeat (3) cycle(1'b1, 2'b11, 1'b0, 2'b00, 1'b1);
    cycle(1'b0, 2'b00, 1'b1, 2'b01, 1'b0);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    for (int i = 0; i < 70; i++) cycle(1'b0, 2'b00, 1'b1, 2'(i), 1'b1);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    repeat (3) cycle(1'b0, 2'b00, 1'b1, 2'b11, 1'b1);
    async_reset_pulse();
    repeat (8) cycle(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      logic v0, v1, ro;
      int mode;
      mode = i / 300;
      v0 = ($urandom_range(0, 3) < ((mode == 2) ? 1 : 3));
      v1 = ($urandom_range(0, 3) < ((mode == 3) ? 1 : 2));
      ro = ($urandom_range(0, 3) < ((mode == 1) ? 1 : 3));
      cycle(v0, 2'($urandom), v1, 2'($urandom), ro);
      if (i == 777) async_reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
